ascon_output_buffer: RTL and testbench
======================================

ASCON_OUTPUT_BUFFER -- requirements
Module: ascon_output_buffer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, number of 64-bit entries (power of two, minimum 4).
REQ-002 The block SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset that is asynchronous and active-high.
REQ-004 The block SHALL have port i_cipher_valid, input, 1, i_cipher holds a valid ciphertext block this cycle.
REQ-005 The block SHALL have port i_cipher, input, 64, ciphertext block from the permutation stage.
REQ-006 The block SHALL have port i_tag_valid, input, 1, i_tag holds a valid tag this cycle.
REQ-007 The block SHALL have port i_tag, input, 128, tag from the permutation stage.
REQ-008 The block SHALL have port i_ready, input, 1, downstream accepts the current beat.
REQ-009 The block SHALL have port o_valid, output, 1, o_data holds a beat.
REQ-010 The block SHALL have port o_data, output, 64, head beat.
REQ-011 The block SHALL have port o_is_tag, output, 1, head beat is a tag half.
REQ-012 The block SHALL have port o_last, output, 1, head beat is the low tag half, i.e. the end of a message.
REQ-013 The block SHALL have port o_count, output, $clog2(FIFO_DEPTH)+1, number of occupied entries.
REQ-014 The block SHALL have port o_full, output, 1, o_count equals FIFO_DEPTH.
REQ-015 The block SHALL have port o_overflow, output, 1, sticky flag set on any dropped write.

Function
REQ-016 Storage SHALL be a circular FIFO of entries {data[63:0], is_tag, last}, with write and read pointers wrapping modulo FIFO_DEPTH.
REQ-017 On i_cipher_valid, the block SHALL push one entry {i_cipher, 0, 0} if at least 1 slot is free.
REQ-018 On i_tag_valid, the block SHALL push two entries in the same cycle, {i_tag[127:64], 1, 0} then {i_tag[63:0], 1, 1}, if at least 2 slots are free; otherwise it SHALL push neither.
REQ-019 Free space SHALL be computed from o_count before the edge; a pop in the same cycle SHALL NOT create write credit.
REQ-020 If i_cipher_valid and i_tag_valid are both high, the block SHALL push the cipher entry only, drop the tag, and set o_overflow.
REQ-021 Any dropped write SHALL set o_overflow on the next edge; o_overflow SHALL stay set until reset.
REQ-022 o_valid SHALL equal (o_count != 0), with first-word fall-through from registered storage.
REQ-023 o_data, o_is_tag and o_last SHALL show the head entry when o_valid=1, and SHALL be 0 when o_valid=0.
REQ-024 A pop SHALL occur when o_valid and i_ready are both high, advancing the read pointer by 1.
REQ-025 i_ready while o_valid=0 SHALL have no effect.
REQ-026 Latency SHALL be as follows: a push at edge N makes the entry visible on the outputs after edge N, with 1-cycle input-to-output latency.
REQ-027 For a simultaneous push and pop, o_count SHALL equal old count + pushed entries − 1.
REQ-028 Output order SHALL equal arrival order, with no reordering between cipher and tag entries.
REQ-029 o_full SHALL be combinational from o_count.

Reset
REQ-030 On reset assertion, the read pointer, write pointer and count SHALL go to 0, and o_overflow, o_valid, o_data, o_is_tag and o_last SHALL go to 0 immediately, without waiting for a clock edge.
REQ-031 The storage array SHALL NOT be required to reset.
REQ-032 While reset is held, writes SHALL be ignored.
REQ-033 Reset asserted mid-stream SHALL discard all buffered entries.

Configuration
REQ-034 With macro ASCON_OUTBUF_STATS_EN defined, the block SHALL add output o_msg_count[15:0], which increments on each pop of an entry with last=1 and wraps from 0xFFFF to 0.
REQ-035 With macro ASCON_OUTBUF_STATS_EN defined, the block SHALL add output o_drop_count[7:0], which increments per dropped write event and saturates at 0xFF.
REQ-036 Both counters SHALL reset to 0 under the same reset as the rest of the block.
REQ-037 With ASCON_OUTBUF_STATS_EN undefined, both ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 The bench SHALL cover: i_ready=1, i_cipher_valid with 0x0123456789ABCDEF -> next cycle o_valid=1, o_data=0x0123456789ABCDEF, o_is_tag=0, o_last=0; then o_count=0.
REQ-039 The bench SHALL cover: i_tag_valid with i_tag=0x00112233445566778899AABBCCDDEEFF, i_ready=1 -> beat 0x0011223344556677 (is_tag=1, last=0), then beat 0x8899AABBCCDDEEFF (is_tag=1, last=1).
REQ-040 The bench SHALL cover: i_ready=0 with five ciphers 1..5 -> o_count=4, o_full=1, o_overflow=1; after i_ready=1, output is 1, 2, 3, 4 in order.
REQ-041 The bench SHALL cover: i_ready=0 with three ciphers, then a tag -> tag dropped, o_count=3, o_overflow=1; with STATS enabled, o_drop_count=1.
REQ-042 The bench SHALL cover: full FIFO, i_ready=1 and i_cipher_valid in the same cycle -> head popped, push dropped, o_count=3, o_overflow=1.
REQ-043 The bench SHALL cover: o_count=3 with reset asserted between edges -> o_valid=0 and o_count=0 before the next edge; after release, a new cipher appears 1 cycle after it is pushed.

Source files
------------

// File: rtl/ascon_output_buffer.sv
// Output FIFO for Ascon ciphertext and tag beats; 1-cycle latency, first-word fall-through.
// Optional statistics counters are enabled by defining ASCON_OUTBUF_STATS_EN.
module ascon_output_buffer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          i_cipher_valid,
  input  logic [63:0]                   i_cipher,
  input  logic                          i_tag_valid,
  input  logic [127:0]                  i_tag,
  input  logic                          i_ready,
  output logic                          o_valid,
  output logic [63:0]                   o_data,
  output logic                          o_is_tag,
  output logic                          o_last,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_full,
  output logic                          o_overflow
`ifdef ASCON_OUTBUF_STATS_EN
  ,
  output logic [15:0]                   o_msg_count,
  output logic [7:0]                    o_drop_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] TAG_LIMIT = CW'(FIFO_DEPTH - 2);

  typedef struct packed {
    logic [63:0] data;
    logic        is_tag;
    logic        last;
  } entry_t;

  entry_t          mem_q [FIFO_DEPTH];
  entry_t          mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1;
  logic [CW-1:0]   count_q, count_d, push_n;
  logic            overflow_q, overflow_d;
  logic            pop, drop;
  entry_t          head;

  assign head = mem_q[rd_ptr_q];
  assign pop  = (count_q != '0) && i_ready;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    push_n     = '0;
    drop       = 1'b0;
    wr_ptr_p1  = wr_ptr_q + PW'(1);

    // Free space uses the pre-edge count, so a same-cycle pop never frees a slot.
    if (i_cipher_valid) begin
      if (count_q < DEPTH_C) begin
        mem_d[wr_ptr_q] = {i_cipher, 1'b0, 1'b0};
        push_n          = CW'(1);
      end else begin
        drop = 1'b1;
      end
      if (i_tag_valid) drop = 1'b1;
    end else if (i_tag_valid) begin
      if (count_q <= TAG_LIMIT) begin
        mem_d[wr_ptr_q]  = {i_tag[127:64], 1'b1, 1'b0};
        mem_d[wr_ptr_p1] = {i_tag[63:0], 1'b1, 1'b1};
        push_n           = CW'(2);
      end else begin
        drop = 1'b1;
      end
    end

    wr_ptr_d = wr_ptr_q + PW'(push_n);
    count_d  = count_q + push_n - CW'(pop);
    if (pop)  rd_ptr_d   = rd_ptr_q + PW'(1);
    if (drop) overflow_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs derive from the async-reset count, so they clear the moment reset rises.
  assign o_valid    = (count_q != '0);
  assign o_data     = o_valid ? head.data   : 64'd0;
  assign o_is_tag   = o_valid ? head.is_tag : 1'b0;
  assign o_last     = o_valid ? head.last   : 1'b0;
  assign o_count    = count_q;
  assign o_full     = (count_q == DEPTH_C);
  assign o_overflow = overflow_q;

`ifdef ASCON_OUTBUF_STATS_EN
  logic [15:0] msg_count_q, msg_count_d;
  logic [7:0]  drop_count_q, drop_count_d;

  always_comb begin
    msg_count_d  = msg_count_q;
    drop_count_d = drop_count_q;
    if (pop && head.last)              msg_count_d  = msg_count_q + 16'd1;
    if (drop && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      msg_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      msg_count_q  <= msg_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign o_msg_count  = msg_count_q;
  assign o_drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_ascon_output_buffer.sv
// Directed bench for ascon_output_buffer (default depth 4, stats disabled).
module tb_ascon_output_buffer;

  logic         clock;
  logic         reset;
  logic         i_cipher_valid;
  logic [63:0]  i_cipher;
  logic         i_tag_valid;
  logic [127:0] i_tag;
  logic         i_ready;
  logic         o_valid;
  logic [63:0]  o_data;
  logic         o_is_tag;
  logic         o_last;
  logic [2:0]   o_count;
  logic         o_full;
  logic         o_overflow;

  int checks = 0;
  int errors = 0;

  ascon_output_buffer #(.FIFO_DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .i_cipher_valid (i_cipher_valid),
    .i_cipher       (i_cipher),
    .i_tag_valid    (i_tag_valid),
    .i_tag          (i_tag),
    .i_ready        (i_ready),
    .o_valid        (o_valid),
    .o_data         (o_data),
    .o_is_tag       (o_is_tag),
    .o_last         (o_last),
    .o_count        (o_count),
    .o_full         (o_full),
    .o_overflow     (o_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; i_cipher_valid = 1'b0; i_cipher = '0;
    i_tag_valid = 1'b0; i_tag = '0; i_ready = 1'b0;
    #3;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_full", 64'(o_full), 64'd0);
    chk("rst_ovf", 64'(o_overflow), 64'd0);
    chk("rst_data", o_data, 64'd0);
    tick();
    reset = 1'b0;

    // Single cipher block passes through with one cycle of latency.
    i_ready = 1'b1; i_cipher_valid = 1'b1; i_cipher = 64'h0123456789ABCDEF;
    tick();
    i_cipher_valid = 1'b0;
    chk("c1_valid", 64'(o_valid), 64'd1);
    chk("c1_data", o_data, 64'h0123456789ABCDEF);
    chk("c1_istag", 64'(o_is_tag), 64'd0);
    chk("c1_last", 64'(o_last), 64'd0);
    tick();
    chk("c1_count", 64'(o_count), 64'd0);
    chk("c1_empty_data", o_data, 64'd0);

    // Tag splits into high half then low half.
    i_tag_valid = 1'b1; i_tag = 128'h00112233445566778899AABBCCDDEEFF;
    tick();
    i_tag_valid = 1'b0;
    chk("t_count", 64'(o_count), 64'd2);
    chk("t_hi_data", o_data, 64'h0011223344556677);
    chk("t_hi_istag", 64'(o_is_tag), 64'd1);
    chk("t_hi_last", 64'(o_last), 64'd0);
    tick();
    chk("t_lo_data", o_data, 64'h8899AABBCCDDEEFF);
    chk("t_lo_istag", 64'(o_is_tag), 64'd1);
    chk("t_lo_last", 64'(o_last), 64'd1);
    tick();
    chk("t_drained", 64'(o_valid), 64'd0);

    // Five ciphers into a stalled depth-4 FIFO: fifth dropped.
    i_ready = 1'b0; i_cipher_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      i_cipher = 64'(k);
      tick();
    end
    i_cipher_valid = 1'b0;
    chk("ov_count", 64'(o_count), 64'd4);
    chk("ov_full", 64'(o_full), 64'd1);
    chk("ov_flag", 64'(o_overflow), 64'd1);
    i_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ov_order%0d", k), o_data, 64'(k));
      tick();
    end
    chk("ov_empty", 64'(o_count), 64'd0);
    chk("ov_sticky", 64'(o_overflow), 64'd1);

    reset = 1'b1; #2;
    chk("rst2_ovf", 64'(o_overflow), 64'd0);
    reset = 1'b0;
    tick();

    // Tag needs two slots; only one is free.
    i_ready = 1'b0; i_cipher_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_cipher = 64'h10 + 64'(k);
      tick();
    end
    i_cipher_valid = 1'b0;
    chk("td_pre_ovf", 64'(o_overflow), 64'd0);
    i_tag_valid = 1'b1; i_tag = {64'hAAAA, 64'hBBBB};
    tick();
    i_tag_valid = 1'b0;
    chk("td_count", 64'(o_count), 64'd3);
    chk("td_ovf", 64'(o_overflow), 64'd1);
    chk("td_head", o_data, 64'h10);

    reset = 1'b1; #2; reset = 1'b0;
    tick();

    // Full FIFO with pop and push together: pop frees no credit.
    i_ready = 1'b0; i_cipher_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_cipher = 64'h20 + 64'(k);
      tick();
    end
    chk("fp_full", 64'(o_full), 64'd1);
    chk("fp_pre_ovf", 64'(o_overflow), 64'd0);
    i_ready = 1'b1; i_cipher = 64'h24;
    tick();
    i_cipher_valid = 1'b0;
    chk("fp_count", 64'(o_count), 64'd3);
    chk("fp_ovf", 64'(o_overflow), 64'd1);
    chk("fp_head", o_data, 64'h21);
    tick();
    chk("fp_d22", o_data, 64'h22);
    tick();
    chk("fp_d23", o_data, 64'h23);
    tick();
    chk("fp_nodrop_push", 64'(o_count), 64'd0);

    // Mid-stream reset clears outputs before any edge and ignores writes.
    i_ready = 1'b0; i_cipher_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_cipher = 64'h30 + 64'(k);
      tick();
    end
    chk("mr_count3", 64'(o_count), 64'd3);
    i_cipher = 64'h99;
    reset = 1'b1; #2;
    chk("mr_valid", 64'(o_valid), 64'd0);
    chk("mr_count", 64'(o_count), 64'd0);
    chk("mr_data", o_data, 64'd0);
    tick();
    chk("mr_wr_ignored", 64'(o_count), 64'd0);
    reset = 1'b0;
    i_cipher = 64'h40;
    tick();
    i_cipher_valid = 1'b0;
    chk("mr_new_valid", 64'(o_valid), 64'd1);
    chk("mr_new_data", o_data, 64'h40);
    chk("mr_new_count", 64'(o_count), 64'd1);

    // Simultaneous push and pop keeps count steady.
    i_ready = 1'b1; i_cipher_valid = 1'b1; i_cipher = 64'h41;
    tick();
    i_cipher_valid = 1'b0;
    chk("pp_count", 64'(o_count), 64'd1);
    chk("pp_data", o_data, 64'h41);
    tick();
    chk("pp_empty", 64'(o_count), 64'd0);
    // Ready with nothing buffered has no effect.
    tick();
    chk("idle_count", 64'(o_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
